// File: rtl/echo_pkg.sv
// Shared constants for the echo stage: sample width, saturation limits,
// FSM state encoding and the 17-to-16-bit saturating helper.
// Imported by echo_if, echo_ram users and the echo_effect top.
package echo_pkg;

  localparam int          SAMPLE_W = 16;
  localparam logic [15:0] SAT_MAX  = 16'h7FFF;
  localparam logic [15:0] SAT_MIN  = 16'h8000;

  // FSM state encoding
  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] RD    = 2'd2;
  localparam logic [1:0] MIX   = 2'd3;

  // Clamp a 17-bit two's-complement sum into 16 bits. Overflow shows up as
  // the two top bits disagreeing; the top bit tells the direction.
  function automatic logic [15:0] sat16(input logic [16:0] s);
    if (s[16] != s[15]) begin
      return s[16] ? SAT_MIN : SAT_MAX;
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/echo_if.sv
// Sample stream bundle between music_player (master) and echo_effect (slave).
// master drives sample_in/sample_in_valid/enable; slave drives sample_out,
// sample_out_valid, ready and the sticky overrun flag.
interface echo_if;
  import echo_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_in_valid;
  logic                enable;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_valid;
  logic                ready;
  logic                overrun;

  modport master (
    output sample_in, sample_in_valid, enable,
    input  sample_out, sample_out_valid, ready, overrun
  );

  modport slave (
    input  sample_in, sample_in_valid, enable,
    output sample_out, sample_out_valid, ready, overrun
  );

endinterface

// File: rtl/echo_ram.sv
// Simple dual-port delay-line memory with registered read, no content reset.
// Ports: clk; write port we/waddr/wdata; read port re/raddr -> q (next cycle).
// q holds its value when re is low.
module echo_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/echo_effect.sv
// Feedback echo: y = sat16(in + (enable ? y[n-2**ADDR_W] >>> DECAY_SHIFT : 0)).
// Ports: clk, reset (async active-high), bus (echo_if.slave). Latency 3 cycles
// strobe-in to strobe-out; strobes while busy are dropped and set overrun.
module echo_effect
  import echo_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DECAY_SHIFT = 1
) (
  input  logic   clk,
  input  logic   reset,
  echo_if.slave  bus
);

  // Reset asserts asynchronously, releases one edge after reset drops, so
  // CLEAR starts cleanly on the following edge.
  logic rst_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 1'b1;
    else       rst_q <= 1'b0;
  end

  logic [1:0]          state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   clr_addr;
  logic [SAMPLE_W-1:0] in_q;
  logic                en_q;
  logic [SAMPLE_W-1:0] out_q;
  logic                out_vld;
  logic                ovr;

  logic [SAMPLE_W-1:0] ram_q;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [SAMPLE_W-1:0] ram_wdata;
  logic                accept;

  logic signed [SAMPLE_W-1:0] dec;
  logic [SAMPLE_W:0]          sum;
  logic [SAMPLE_W-1:0]        mix_y;

  assign accept = (state == IDLE) && bus.sample_in_valid;

  // CLEAR zero-fills the line; MIX writes the new output back at ptr. Reads
  // at ptr happen on accept, two cycles before that write, so the two never
  // collide on one address in the same cycle.
  always_comb begin
    ram_we    = ((state == CLEAR) && !rst_q) || (state == MIX);
    ram_waddr = (state == MIX) ? ptr : clr_addr;
    ram_wdata = (state == MIX) ? mix_y : '0;
  end

  echo_ram #(.ADDR_W(ADDR_W), .DATA_W(SAMPLE_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (ptr),
    .q     (ram_q)
  );

  // Mixer: decayed history plus sign-extended input, then saturate.
  always_comb begin
    dec   = $signed(ram_q) >>> DECAY_SHIFT;
    sum   = {in_q[SAMPLE_W-1], in_q} + (en_q ? {dec[SAMPLE_W-1], dec} : '0);
    mix_y = sat16(sum);
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state    <= CLEAR;
      ptr      <= '0;
      clr_addr <= '0;
      in_q     <= '0;
      en_q     <= 1'b0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == {ADDR_W{1'b1}}) state <= IDLE;
        end
        IDLE: begin
          if (bus.sample_in_valid) begin
            in_q  <= bus.sample_in;
            en_q  <= bus.enable;
            state <= RD;
          end
        end
        RD: begin
          if (bus.sample_in_valid) ovr <= 1'b1;
          state <= MIX;
        end
        MIX: begin
          if (bus.sample_in_valid) ovr <= 1'b1;
          out_q   <= mix_y;
          out_vld <= 1'b1;
          ptr     <= ptr + ADDR_W'(1);
          state   <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.sample_out       = out_q;
  assign bus.sample_out_valid = out_vld;
  assign bus.ready            = (state == IDLE);
  assign bus.overrun          = ovr;

endmodule

// File: tb/tb_echo_effect.sv
module tb_echo_effect;

  localparam int ADDR_W = 3;
  localparam int DELAY  = 1 << ADDR_W;
  localparam int DECAY  = 1;

  logic clk;
  logic reset;
  echo_if bus();

  echo_effect #(.ADDR_W(ADDR_W), .DECAY_SHIFT(DECAY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: full output history since the last reset; RAM starts zeroed.
  logic [15:0] hist[$];

  function automatic logic [15:0] model_step(input logic [15:0] x, input logic e);
    int n, prev, s;
    n    = hist.size();
    prev = (n >= DELAY) ? int'($signed(hist[n-DELAY])) : 0;
    s    = int'($signed(x)) + (e ? (prev >>> DECAY) : 0);
    if (s > 32767)       s = 32767;
    else if (s < -32768) s = -32768;
    hist.push_back(s[15:0]);
    return s[15:0];
  endfunction

  // One strobe, then a 10-cycle window. Enable is flipped right after the
  // accept edge; only the value at accept may matter.
  task automatic send(input logic [15:0] x, input logic e,
                      output logic [15:0] got, output int lat, output int nv);
    bus.sample_in = x;
    bus.enable = e;
    bus.sample_in_valid = 1'b1;
    lat = -1; nv = 0; got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.sample_in_valid = 1'b0;
        bus.enable = ~e;
      end
      if (bus.sample_out_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin
          lat = k;
          got = bus.sample_out;
        end
      end
    end
  endtask

  task automatic do_reset();
    bus.sample_in_valid = 1'b0;
    bus.sample_in = '0;
    bus.enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    for (int k = 0; k < 20 && bus.ready !== 1'b1; k++) @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_timeout: ready=%b want 1", bus.ready);
    end
  endtask

  task automatic test_reset();
    bus.sample_in_valid = 1'b0;
    bus.sample_in = '0;
    bus.enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.sample_out, bus.sample_out_valid, bus.ready, bus.overrun} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_outputs: out=%h vld=%b rdy=%b ovr=%b want all 0",
               bus.sample_out, bus.sample_out_valid, bus.ready, bus.overrun);
    end
    reset = 1'b0;
    hist.delete();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b0 || bus.sample_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL clear_busy[%0d]: rdy=%b vld=%b want 0 0", i, bus.ready, bus.sample_out_valid);
      end
      // strobes during CLEAR must be ignored
      bus.sample_in = 16'h5555;
      bus.sample_in_valid = (i >= 2 && i <= 4);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.overrun !== 1'b0 || bus.sample_out !== 16'h0) begin
      n_err++;
      $display("FAIL clear_done: rdy=%b ovr=%b out=%h want 1 0 0000",
               bus.ready, bus.overrun, bus.sample_out);
    end
  endtask

  task automatic test_impulse();
    logic [15:0] got, exp, spec;
    int lat, nv;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      logic [15:0] x;
      x = (n == 0) ? 16'h4000 : 16'h0000;
      exp = model_step(x, 1'b1);
      spec = (n == 0) ? 16'h4000 : (n == 8) ? 16'h2000 : (n == 16) ? 16'h1000 : 16'h0000;
      send(x, 1'b1, got, lat, nv);
      n_cmp++;
      if (got !== exp || got !== spec) begin
        n_err++;
        $display("FAIL impulse_out[%0d]: got %h want %h", n, got, spec);
      end
      n_cmp++;
      if (lat != 3 || nv != 1) begin
        n_err++;
        $display("FAIL impulse_timing[%0d]: latency %0d strobes %0d want 3 1", n, lat, nv);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] got, exp, spec;
    int lat, nv;
    logic [15:0] lvl[2];
    lvl[0] = 16'h7000;
    lvl[1] = 16'h9000;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int n = 0; n < 14; n++) begin
        exp = model_step(lvl[t], 1'b1);
        spec = (n < 8) ? lvl[t] : ((t == 0) ? 16'h7FFF : 16'h8000);
        send(lvl[t], 1'b1, got, lat, nv);
        n_cmp++;
        if (got !== exp || got !== spec || lat != 3) begin
          n_err++;
          $display("FAIL sat_%h[%0d]: got %h lat %0d want %h lat 3", lvl[t], n, got, lat, spec);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] got, exp, spec;
    int lat, nv;
    do_reset();
    for (int n = 0; n < 11; n++) begin
      logic [15:0] x;
      logic e;
      x = (n == 0) ? 16'h1234 : (n == 1) ? 16'h0001 : 16'h0000;
      e = (n >= 8);
      exp = model_step(x, e);
      spec = (n == 0) ? 16'h1234 : (n == 1) ? 16'h0001 : (n == 8) ? 16'h091A : 16'h0000;
      send(x, e, got, lat, nv);
      n_cmp++;
      if (got !== exp || got !== spec || lat != 3 || nv != 1) begin
        n_err++;
        $display("FAIL bypass[%0d]: got %h lat %0d n %0d want %h lat 3 n 1", n, got, lat, nv, spec);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    int lat, nv;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] x;
      logic e;
      x = 16'($urandom);
      e = 1'($urandom_range(0, 1));
      exp = model_step(x, e);
      send(x, e, got, lat, nv);
      n_cmp++;
      if (got !== exp || lat != 3 || nv != 1) begin
        n_err++;
        $display("FAIL random[%0d]: in %h en %b got %h lat %0d want %h lat 3", n, x, e, got, lat, exp);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] x1, got, exp;
    int lat, nv;
    do_reset();
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_initial: got %b want 0", bus.overrun);
    end
    x1 = 16'($urandom_range(1, 16'h3FFF));
    exp = model_step(x1, 1'b1);
    bus.sample_in = x1;
    bus.enable = 1'b1;
    bus.sample_in_valid = 1'b1;
    lat = -1; nv = 0; got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.sample_in = ~x1;          // second back-to-back strobe
      if (k == 2) bus.sample_in_valid = 1'b0;
      if (bus.sample_out_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin lat = k; got = bus.sample_out; end
      end
    end
    n_cmp++;
    if (nv != 1 || got !== exp || lat != 3) begin
      n_err++;
      $display("FAIL overrun_accept: strobes %0d got %h lat %0d want 1 %h 3", nv, got, lat, exp);
    end
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b want 1", bus.overrun);
    end
    for (int n = 0; n < 2; n++) begin
      logic [15:0] x;
      x = 16'($urandom);
      exp = model_step(x, 1'b1);
      send(x, 1'b1, got, lat, nv);
      n_cmp++;
      if (got !== exp || bus.overrun !== 1'b1) begin
        n_err++;
        $display("FAIL overrun_sticky[%0d]: got %h ovr %b want %h ovr 1", n, got, bus.overrun, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp, spec;
    int lat, nv;
    // fill the delay line with nonzero bypass data (overrun still set from before)
    for (int n = 0; n < DELAY; n++) begin
      logic [15:0] x;
      x = 16'($urandom) | 16'h0001;
      exp = model_step(x, 1'b0);
      send(x, 1'b0, got, lat, nv);
    end
    bus.sample_in = 16'h4000;
    bus.enable = 1'b1;
    bus.sample_in_valid = 1'b1;
    @(negedge clk);                               // accepted, now in RD
    bus.sample_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.sample_out, bus.sample_out_valid, bus.ready, bus.overrun} !== 19'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: out=%h vld=%b rdy=%b ovr=%b want all 0",
               bus.sample_out, bus.sample_out_valid, bus.ready, bus.overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b0 || bus.sample_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_clear[%0d]: rdy=%b vld=%b want 0 0", i, bus.ready, bus.sample_out_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_ready: got %b want 1", bus.ready);
    end
    for (int n = 0; n < 12; n++) begin
      logic [15:0] x;
      x = (n == 0) ? 16'h4000 : 16'h0000;
      exp = model_step(x, 1'b1);
      spec = (n == 0) ? 16'h4000 : (n == 8) ? 16'h2000 : 16'h0000;
      send(x, 1'b1, got, lat, nv);
      n_cmp++;
      if (got !== exp || got !== spec || lat != 3) begin
        n_err++;
        $display("FAIL midreset_impulse[%0d]: got %h lat %0d want %h lat 3", n, got, lat, spec);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.sample_in = '0;
    bus.sample_in_valid = 1'b0;
    bus.enable = 1'b0;
    test_reset();
    test_impulse();
    test_saturation();
    test_bypass();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
